// File: rtl/cpu_step_pkg.sv
// Shared types and constants for the CPU step/run clock-enable controller.
package cpu_step_pkg;

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_RUN_DIV         = 5000000;

  // Bits needed for a counter holding 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus level debounce for one active-low key;
// emits a one-cycle press pulse on an accepted 1->0 transition.
module key_debounce
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic            stable;
  logic [DB_W-1:0] cnt;

  // Synchronizer and debounce counter preset to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
        press  <= ~sync[1];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU advance-enable generator: manual single-step or free-running at
// RUN_DIV cycles per pulse, all in the single clk domain.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_step_n,
  input  logic             key_run_n,
  input  logic             halt_i,
  output logic             cpu_en,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned PS_W = cnt_w(RUN_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(RUN_DIV - 1);

  logic step_press;
  logic run_press;

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] presc;
  logic [PS_W-1:0] presc_nxt;
  logic            en_nxt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_step_n),
    .press   (step_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_run_n),
    .press   (run_press)
  );

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_STEP;
      presc    <= '0;
      cpu_en   <= 1'b0;
      run_mode <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      cpu_en   <= en_nxt;
      run_mode <= (state_nxt == ST_RUN);
      step_cnt <= step_cnt + CNT_W'(en_nxt);
    end
  end

  // Next state; a run press outranks a step press, halt blocks everything.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    en_nxt    = 1'b0;
    case (state)
      ST_STEP: begin
        if (!halt_i) begin
          if (run_press) begin
            state_nxt = ST_RUN;
            presc_nxt = '0;
          end else if (step_press && !cpu_en) begin
            en_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        presc_nxt = (presc == PS_MAX) ? '0 : presc + PS_W'(1);
        if (halt_i) begin
          state_nxt = ST_STEP;
        end else begin
          en_nxt = (presc == PS_MAX);
          if (run_press) state_nxt = ST_STEP;
        end
      end
      default: state_nxt = ST_STEP;
    endcase
  end

endmodule
